execute_wb_arbiter: RTL and testbench
=====================================

EXECUTE_WB_ARBITER -- requirements
Module: execute_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4: number of functional-unit result channels.
REQ-002 SHALL have parameter NUM_CDB, default 2: number of CDB broadcast ports, 1 <= NUM_CDB <= NUM_FU.
REQ-003 SHALL have parameter BUF_DEPTH, default 2: result entries buffered per FU, >= 1.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous squash of all buffered results.
REQ-007 fu_val  input  [NUM_FU]  FU i presents a result.
REQ-008 fu_pkt  input  [NUM_FU] x writeback_packet_t  FU i result payload.
REQ-009 fu_rdy  output  [NUM_FU]  FU i buffer can accept a result this cycle.
REQ-010 cdb_val  output  [NUM_CDB]  CDB port j carries a valid result.
REQ-011 cdb_pkt  output  [NUM_CDB] x writeback_packet_t  CDB port j payload.
REQ-012 cdb_src  output  [NUM_CDB] x $clog2(NUM_FU)  index of the FU granted to port j.

Function
REQ-013 Each FU channel SHALL own an in-order FIFO of BUF_DEPTH entries; enqueue when fu_val[i] && fu_rdy[i].
REQ-014 fu_rdy[i] SHALL equal (count[i] < BUF_DEPTH) from registered count only; a full FIFO SHALL NOT accept, even when dequeuing that cycle (no pass-through).
REQ-015 There SHALL be no empty bypass: a result enqueued in cycle t is first visible on the CDB in cycle t+1.
REQ-016 The arbiter SHALL scan FUs from rr_ptr upward, modulo NUM_FU, and grant the first NUM_CDB non-empty FIFO heads to ports 0..NUM_CDB-1 in scan order.
REQ-017 Every granted head SHALL be dequeued in the same cycle; ungranted ports SHALL drive cdb_val=0, cdb_pkt=0, cdb_src=0.
REQ-018 rr_ptr SHALL update to (last granted index + 1) mod NUM_FU; it SHALL stay unchanged when nothing is granted.
REQ-019 Simultaneous enqueue and dequeue on one FIFO SHALL leave the count unchanged and preserve order.
REQ-020 count arithmetic SHALL use $clog2(BUF_DEPTH+1) bits; read/write pointers SHALL wrap at BUF_DEPTH, including non-power-of-two depths.
REQ-021 When flush=1:
  - cdb_val SHALL be all-zero that cycle.
  - Enqueues that cycle SHALL be dropped.
  - All counts and pointers SHALL clear at the edge.
  - rr_ptr SHALL clear to 0.
REQ-022 cdb_val/cdb_pkt/cdb_src SHALL be combinational from FIFO heads, arbiter state and flush.

Reset
REQ-023 While rst=0, the following SHALL apply asynchronously:
  - All FIFOs empty, rr_ptr=0.
  - cdb_val=0, cdb_pkt=0, cdb_src=0.
  - fu_rdy=0.
REQ-024 Results presented while rst=0 SHALL be discarded; after release, fu_rdy SHALL be all-ones in the first cycle.
REQ-025 Reset mid-operation SHALL discard buffered results without emitting them.

Structure
REQ-026 writeback_packet_t and the NUM_FU/NUM_CDB defaults SHALL live in uarch_pkg; no new local typedefs.
REQ-027 The per-FU FIFO SHALL be one sub-module, wb_fifo (params DEPTH, payload type), instantiated NUM_FU times via generate.
REQ-028 The arbiter (scan and grant) SHALL be inline combinational logic in execute_wb_arbiter.

Verification (NUM_FU=4, NUM_CDB=2, BUF_DEPTH=2)
REQ-029 Single result:
  - Stimulus: FU1 sends 0xA1 in cycle 0, others idle.
  - Cycle 1: port0 val=1, pkt=0xA1, src=1; port1 val=0.
  - Cycle 2: rr_ptr=2.
REQ-030 All FUs burst:
  - Stimulus: all 4 FUs valid in cycle 0 with rr_ptr=0.
  - Cycle 1: ports carry FU0, FU1.
  - Cycle 2: ports carry FU2, FU3.
  - Cycle 3: all invalid; rr_ptr=0.
REQ-031 Sustained backpressure:
  - Stimulus: all 4 FUs hold fu_val=1 for 20 cycles with incrementing payloads.
  - fu_rdy deasserts on full FIFOs.
  - Exactly 2 results per cycle once the pipeline is filled.
  - Each FU granted once per 2 cycles.
  - Per-FU order preserved; no loss or duplication.
REQ-032 Wrap-around:
  - Setup: rr_ptr=3, only FU3 and FU0 non-empty.
  - Port0 carries FU3, port1 carries FU0.
  - rr_ptr becomes 1.
REQ-033 Flush:
  - Setup: 3 results buffered; flush=1 together with a new FU2 result.
  - That cycle: cdb_val=00.
  - Next cycle: all FIFOs empty, fu_rdy=1111, FU2 result never appears.
REQ-034 Async reset:
  - Stimulus: rst=0 between clock edges with 4 results buffered.
  - cdb_val=00 and fu_rdy=0000 immediately, before the next edge.
  - After release: nothing is emitted and fu_rdy=1111.

Source files
------------

// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and defaults for the execute/writeback path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uarch_pkg;

  localparam int NUM_FU_DEFAULT  = 4;
  localparam int NUM_CDB_DEFAULT = 2;
  localparam int ROB_TAG_W       = 6;
  localparam int XLEN            = 32;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [XLEN-1:0]      data;
  } writeback_packet_t;

  // Index width that stays legal (>= 1 bit) for a single-entry range.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-FU in-order result FIFO with synchronous squash.
// Latency: one cycle enqueue-to-head; no empty bypass.
// Backpressure: rdy from registered count only; a full FIFO never accepts.
module wb_fifo
  import uarch_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = writeback_packet_t
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  T     push_pkt,
  input  logic pop,
  output T     head_pkt,
  output logic head_vld,
  output logic rdy
);

  localparam int PW = idx_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Pointers wrap explicitly at DEPTH so non-power-of-two depths work.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // rdy is forced low while reset is held so nothing is accepted then.
  assign rdy      = rst && (cnt_q < CW'(DEPTH));
  assign head_vld = (cnt_q != '0);
  assign head_pkt = mem_q[rd_q];
  assign do_push  = push && rdy && !flush;
  assign do_pop   = pop && head_vld && !flush;

  // Next-state for pointers and occupancy; flush empties everything.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wrap_inc(wr_q);
      if (do_pop)  rd_d = wrap_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_pkt;
  end

endmodule

// File: rtl/execute_wb_arbiter.sv
// Buffers FU results and round-robin grants up to NUM_CDB heads per cycle onto the CDB.
// Latency: result visible on the CDB one cycle after enqueue; CDB outputs are combinational.
// Backpressure: fu_rdy drops when an FU's buffer is full; granted heads dequeue same cycle.
module execute_wb_arbiter
  import uarch_pkg::*;
#(
  parameter  int NUM_FU    = NUM_FU_DEFAULT,
  parameter  int NUM_CDB   = NUM_CDB_DEFAULT,
  parameter  int BUF_DEPTH = 2,
  localparam int SW        = idx_w(NUM_FU)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic              [NUM_FU-1:0]    fu_val,
  input  writeback_packet_t [NUM_FU-1:0]    fu_pkt,
  output logic              [NUM_FU-1:0]    fu_rdy,
  output logic              [NUM_CDB-1:0]   cdb_val,
  output writeback_packet_t [NUM_CDB-1:0]   cdb_pkt,
  output logic [NUM_CDB-1:0][SW-1:0]        cdb_src
);

  logic              [NUM_FU-1:0] head_vld;
  logic              [NUM_FU-1:0] grant;
  writeback_packet_t [NUM_FU-1:0] head_pkt;
  logic              [SW-1:0]     rr_q, rr_d;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    wb_fifo #(
      .DEPTH (BUF_DEPTH),
      .T     (writeback_packet_t)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .push     (fu_val[i]),
      .push_pkt (fu_pkt[i]),
      .pop      (grant[i]),
      .head_pkt (head_pkt[i]),
      .head_vld (head_vld[i]),
      .rdy      (fu_rdy[i])
    );
  end

  // Scan from rr_q upward, handing non-empty heads to ports 0..NUM_CDB-1 in scan order.
  always_comb begin
    int            slot;
    int            sum;
    logic [SW-1:0] idx;
    grant   = '0;
    cdb_val = '0;
    cdb_pkt = '0;
    cdb_src = '0;
    rr_d    = rr_q;
    slot    = 0;
    sum     = 0;
    idx     = '0;
    if (flush) begin
      rr_d = '0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        sum = int'(rr_q) + k;
        if (sum >= NUM_FU) sum = sum - NUM_FU;
        idx = SW'(sum);
        if (head_vld[idx] && (slot < NUM_CDB)) begin
          grant[idx] = 1'b1;
          for (int j = 0; j < NUM_CDB; j++) begin
            if (slot == j) begin
              cdb_val[j] = 1'b1;
              cdb_pkt[j] = head_pkt[idx];
              cdb_src[j] = idx;
            end
          end
          slot = slot + 1;
          rr_d = (sum == NUM_FU - 1) ? '0 : SW'(sum + 1);
        end
      end
    end
  end

  // Round-robin pointer; holds when nothing is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= '0;
    else      rr_q <= rr_d;
  end

endmodule

// File: tb/tb_execute_wb_arbiter.sv
// Bench for execute_wb_arbiter: queue-based reference model checked every cycle
// plus directed scenarios with hand-computed expectations.
// Runs with NUM_FU=4, NUM_CDB=2, BUF_DEPTH=2.
module tb_execute_wb_arbiter;
  import uarch_pkg::*;

  localparam int NF = 4;
  localparam int NC = 2;
  localparam int BD = 2;
  localparam int SW = 2;

  logic                            clk   = 1'b0;
  logic                            rst   = 1'b0;
  logic                            flush = 1'b0;
  logic              [NF-1:0]      fu_val = '0;
  writeback_packet_t [NF-1:0]      fu_pkt;
  logic              [NF-1:0]      fu_rdy;
  logic              [NC-1:0]      cdb_val;
  writeback_packet_t [NC-1:0]      cdb_pkt;
  logic [NC-1:0][SW-1:0]           cdb_src;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  execute_wb_arbiter #(.NUM_FU(NF), .NUM_CDB(NC), .BUF_DEPTH(BD)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .fu_val  (fu_val),
    .fu_pkt  (fu_pkt),
    .fu_rdy  (fu_rdy),
    .cdb_val (cdb_val),
    .cdb_pkt (cdb_pkt),
    .cdb_src (cdb_src)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic writeback_packet_t mk(input logic [31:0] d);
    writeback_packet_t p;
    p.rob_tag = d[5:0];
    p.data    = d;
    return p;
  endfunction

  // Reference model: one queue per FU plus a scan start index.
  writeback_packet_t mq [NF][$];
  int m_rr = 0;

  // Sample between edges: compare against model, then advance model to the next edge.
  always @(negedge clk) begin : p_model
    int ng;
    int fu;
    int last;
    logic [NF-1:0] e_rdy;
    logic [NF-1:0] gr;
    if (!rst) begin
      chk("model_rst_cdb_val", cdb_val, '0);
      chk("model_rst_fu_rdy", fu_rdy, '0);
      for (int i = 0; i < NF; i++) mq[i].delete();
      m_rr = 0;
    end else begin
      ng   = 0;
      last = -1;
      gr   = '0;
      for (int i = 0; i < NF; i++) e_rdy[i] = (mq[i].size() < BD);
      for (int k = 0; k < NF; k++) begin
        fu = (m_rr + k) % NF;
        if (!flush && mq[fu].size() > 0 && ng < NC) begin
          chk("model_val", cdb_val[ng], 1);
          chk("model_pkt", cdb_pkt[ng], mq[fu][0]);
          chk("model_src", cdb_src[ng], fu);
          gr[fu] = 1'b1;
          last   = fu;
          ng++;
        end
      end
      for (int p = ng; p < NC; p++) begin
        chk("model_idle_val", cdb_val[p], 0);
        chk("model_idle_pkt", cdb_pkt[p], 0);
        chk("model_idle_src", cdb_src[p], 0);
      end
      chk("model_fu_rdy", fu_rdy, e_rdy);
      if (flush) begin
        for (int i = 0; i < NF; i++) mq[i].delete();
        m_rr = 0;
      end else begin
        for (int i = 0; i < NF; i++) if (gr[i]) void'(mq[i].pop_front());
        if (last >= 0) m_rr = (last + 1) % NF;
        for (int i = 0; i < NF; i++) if (fu_val[i] && e_rdy[i]) mq[i].push_back(fu_pkt[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq [NF];
    int gcnt [NF];
    int total_out;
    int sum;
    logic [NF-1:0] acc;

    // Reset held with FUs presenting results: all discarded.
    fu_val = 4'b1111;
    for (int i = 0; i < NF; i++) fu_pkt[i] = mk(32'h0000_0E00 + i);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cdb_val", cdb_val, 2'b00);
    chk("reset_fu_rdy", fu_rdy, 4'b0000);
    fu_val = '0;
    rst    = 1'b1;
    #1;
    chk("release_fu_rdy", fu_rdy, 4'b1111);
    chk("release_cdb_val", cdb_val, 2'b00);
    tick();
    chk("release_nothing_emitted", cdb_val, 2'b00);

    // Single result from FU1.
    fu_val = 4'b0010; fu_pkt[1] = mk(32'hA1);
    tick(); fu_val = '0;
    chk("single_val", cdb_val, 2'b01);
    chk("single_pkt", cdb_pkt[0], mk(32'hA1));
    chk("single_src", cdb_src[0], 1);
    tick();
    chk("single_after", cdb_val, 2'b00);
    // rr now 2: FU2 must win over FU0.
    fu_val = 4'b0101; fu_pkt[0] = mk(32'hB0); fu_pkt[2] = mk(32'hB2);
    tick(); fu_val = '0;
    chk("rr2_val", cdb_val, 2'b11);
    chk("rr2_src0", cdb_src[0], 2);
    chk("rr2_pkt0", cdb_pkt[0], mk(32'hB2));
    chk("rr2_src1", cdb_src[1], 0);
    chk("rr2_pkt1", cdb_pkt[1], mk(32'hB0));
    tick();

    // Idle flush returns rr to 0.
    flush = 1'b1;
    tick(); flush = 1'b0;

    // All four FUs at once.
    fu_val = 4'b1111;
    for (int i = 0; i < NF; i++) fu_pkt[i] = mk(32'hC0 + i);
    tick(); fu_val = '0;
    chk("burst4_c1_src0", cdb_src[0], 0);
    chk("burst4_c1_src1", cdb_src[1], 1);
    chk("burst4_c1_pkt1", cdb_pkt[1], mk(32'hC1));
    tick();
    chk("burst4_c2_src0", cdb_src[0], 2);
    chk("burst4_c2_src1", cdb_src[1], 3);
    chk("burst4_c2_pkt0", cdb_pkt[0], mk(32'hC2));
    tick();
    chk("burst4_c3_val", cdb_val, 2'b00);
    // rr back at 0: FU0 precedes FU3.
    fu_val = 4'b1001; fu_pkt[0] = mk(32'hD0); fu_pkt[3] = mk(32'hD3);
    tick(); fu_val = '0;
    chk("rr0_src0", cdb_src[0], 0);
    chk("rr0_src1", cdb_src[1], 3);
    tick();

    // Wrap-around: FU2 alone puts rr at 3, then FU3 precedes FU0.
    fu_val = 4'b0100; fu_pkt[2] = mk(32'hD2);
    tick(); fu_val = '0;
    chk("wrap_setup_src", cdb_src[0], 2);
    tick();
    fu_val = 4'b1001; fu_pkt[0] = mk(32'hE0); fu_pkt[3] = mk(32'hE3);
    tick(); fu_val = '0;
    chk("wrap_src0", cdb_src[0], 3);
    chk("wrap_pkt0", cdb_pkt[0], mk(32'hE3));
    chk("wrap_src1", cdb_src[1], 0);
    chk("wrap_pkt1", cdb_pkt[1], mk(32'hE0));
    tick();
    // rr now 1: FU1 precedes FU0.
    fu_val = 4'b0011; fu_pkt[0] = mk(32'hF0); fu_pkt[1] = mk(32'hF1);
    tick(); fu_val = '0;
    chk("rr1_src0", cdb_src[0], 1);
    chk("rr1_src1", cdb_src[1], 0);
    tick();

    // Flush with three buffered and a new FU2 result.
    fu_val = 4'b1011;
    fu_pkt[0] = mk(32'h60); fu_pkt[1] = mk(32'h61); fu_pkt[3] = mk(32'h63);
    tick();
    fu_val = 4'b0100; fu_pkt[2] = mk(32'h62); flush = 1'b1;
    #1;
    chk("flush_cycle_val", cdb_val, 2'b00);
    tick(); fu_val = '0; flush = 1'b0;
    chk("flush_next_val", cdb_val, 2'b00);
    chk("flush_next_rdy", fu_rdy, 4'b1111);
    tick();
    chk("flush_no_fu2", cdb_val, 2'b00);

    // Sustained backpressure for 20 cycles; payload advances only when accepted.
    total_out = 0;
    for (int i = 0; i < NF; i++) begin seq[i] = 0; gcnt[i] = 0; end
    for (int cyc = 0; cyc < 20; cyc++) begin
      fu_val = 4'b1111;
      for (int i = 0; i < NF; i++) fu_pkt[i] = mk(32'h1000 * (i + 1) + seq[i]);
      #1;
      acc = fu_rdy;
      if (cyc == 2) chk("bp_rdy_c2", fu_rdy, 4'b0011);
      if (cyc == 3) chk("bp_rdy_c3", fu_rdy, 4'b1100);
      if (cyc >= 1) chk("bp_rate", $countones(cdb_val), 2);
      if (cyc >= 4 && cyc < 12)
        for (int p = 0; p < NC; p++) if (cdb_val[p]) gcnt[cdb_src[p]]++;
      total_out += $countones(cdb_val);
      tick();
      for (int i = 0; i < NF; i++) if (acc[i]) seq[i]++;
    end
    fu_val = '0;
    repeat (4) begin
      total_out += $countones(cdb_val);
      tick();
    end
    sum = 0;
    for (int i = 0; i < NF; i++) sum += seq[i];
    chk("bp_accepted", sum, 44);
    chk("bp_no_loss_dup", total_out, sum);
    for (int i = 0; i < NF; i++) chk("bp_fair", gcnt[i], 4);
    chk("bp_drained", cdb_val, 2'b00);

    // Asynchronous reset with four buffered results.
    fu_val = 4'b1111;
    for (int i = 0; i < NF; i++) fu_pkt[i] = mk(32'h70 + i);
    tick(); fu_val = '0;
    #2 rst = 1'b0;
    #1;
    chk("arst_val", cdb_val, 2'b00);
    chk("arst_rdy", fu_rdy, 4'b0000);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("arst_release_rdy", fu_rdy, 4'b1111);
    chk("arst_release_val", cdb_val, 2'b00);
    tick();
    chk("arst_nothing_later", cdb_val, 2'b00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
